wb_slave_regs: RTL and testbench

WB_SLAVE_REGS -- requirements
Module: wb_slave_regs

---
 rtl/wb_slave_regs.sv | 118 +++++++++++
 tb/tb_wb_slave_regs.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_regs.sv
// Wishbone register slave: control, interrupt and scratch registers
// with a single-cycle registered ack/err response.
module wb_slave_regs #(
  parameter int          INT_W    = 8,
  parameter logic [31:0] CTRL_RST = 32'h0000_A000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [11:2]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             int_o,
  input  logic [INT_W-1:0] irq_evt_i,
  output logic [31:0]      ctrl_o
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [31:0]      ctrl;
  logic [31:0]      scratch;
  logic [31:0]      xfer_cnt;
  logic [INT_W-1:0] int_src;
  logic [INT_W-1:0] int_mask;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      dat_q;
  logic             int_q;

  logic        req;
  logic        bad;
  logic        wr;
  logic [31:0] bm;
  logic [31:0] rd;
  logic [INT_W-1:0] clr;

  assign req = wb_cyc_i & wb_stb_i & (state == IDLE);
  assign bad = (wb_adr_i > 10'd4) |
               (wb_we_i & (wb_adr_i == 10'd4));
  assign wr  = req & ~bad & wb_we_i;

  assign bm = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
               {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

  assign clr = (wr && wb_adr_i == 10'd1) ?
               (wb_dat_i[INT_W-1:0] & bm[INT_W-1:0]) :
               '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = RESP;
      RESP: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    case (wb_adr_i)
      10'd0:   rd = ctrl;
      10'd1:   rd = 32'(int_src);
      10'd2:   rd = 32'(int_mask);
      10'd3:   rd = scratch;
      10'd4:   rd = xfer_cnt;
      default: rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      ctrl     <= CTRL_RST;
      scratch  <= '0;
      xfer_cnt <= '0;
      int_src  <= '0;
      int_mask <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      int_q    <= 1'b0;
    end else begin
      state <= state_nx;
      ack_q <= req & ~bad;
      err_q <= req & bad;
      dat_q <= (req & ~bad & ~wb_we_i) ? rd : '0;
      int_q <= |(int_src & int_mask);
      // Event set wins over a coincident W1C clear
      int_src <= (int_src & ~clr) | irq_evt_i;
      if (wr && wb_adr_i == 10'd0)
        ctrl <= (ctrl & ~bm) | (wb_dat_i & bm);
      if (wr && wb_adr_i == 10'd2)
        int_mask <= (int_mask & ~bm[INT_W-1:0]) |
                    (wb_dat_i[INT_W-1:0] & bm[INT_W-1:0]);
      if (wr && wb_adr_i == 10'd3)
        scratch <= (scratch & ~bm) | (wb_dat_i & bm);
      if (wb_ack_o)
        xfer_cnt <= xfer_cnt + 32'd1;
    end
  end

  // Reset during RESP suppresses the pending termination
  assign wb_ack_o = ack_q & ~wb_rst_i;
  assign wb_err_o = err_q & ~wb_rst_i;
  assign wb_dat_o = wb_rst_i ? '0 : dat_q;
  assign int_o    = int_q;
  assign ctrl_o   = ctrl;

endmodule

// File: tb/tb_wb_slave_regs.sv
// Self-checking bench for wb_slave_regs: directed scenarios plus
// randomized accesses against a register-map reference model.
module tb_wb_slave_regs;

  logic        clk;
  logic        rst;
  logic [11:2] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        irq_int;
  logic [7:0]  evt;
  logic [31:0] ctrl;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] m_ctrl, m_src, m_mask, m_scr, m_cnt;

  wb_slave_regs dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .int_o     (irq_int),
    .irq_evt_i (evt),
    .ctrl_o    (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [9:0] a);
    case (a)
      10'd0:   return m_ctrl;
      10'd1:   return m_src;
      10'd2:   return m_mask;
      10'd3:   return m_scr;
      10'd4:   return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return (m_src & m_mask) != 0;
  endfunction

  task automatic model_reset();
    m_ctrl = 32'h0000_A000;
    m_src  = 0;
    m_mask = 0;
    m_scr  = 0;
    m_cnt  = 0;
  endtask

  task automatic access(input logic [9:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [7:0] e);
    logic        is_bad;
    logic [31:0] exp_d;
    @(negedge clk);
    adr = a; we = w; dat_w = d; sel = s; evt = e;
    cyc = 1'b1; stb = 1'b1;
    check("pre_ack", {31'b0, ack}, 0);
    check("pre_dat", dat_r, 0);
    is_bad = (a > 10'd4) || (w && a == 10'd4);
    exp_d  = (!is_bad && !w) ? mread(a) : 32'h0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; evt = '0;
    check("ack", {31'b0, ack}, {31'b0, !is_bad});
    check("err", {31'b0, err}, {31'b0, is_bad});
    check("dat", dat_r, exp_d);
    if (!is_bad && w) begin
      case (a)
        10'd0: m_ctrl = merge(m_ctrl, d, s);
        10'd1:
          for (int i = 0; i < 8; i++)
            if (s[i/8] && d[i]) m_src[i] = 1'b0;
        10'd2: m_mask = merge(m_mask, d, s) & 32'hFF;
        10'd3: m_scr = merge(m_scr, d, s);
        default: ;
      endcase
    end
    m_src = m_src | {24'b0, e};
    if (!is_bad) m_cnt = m_cnt + 1;
    @(posedge clk); #1;
    check("ctrl_o", ctrl, m_ctrl);
    check("int_o", {31'b0, irq_int}, {31'b0, m_int()});
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0;
    we = 1'b0; stb = 1'b0; cyc = 1'b0; evt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_dat", dat_r, 0);
    check("rst_int", {31'b0, irq_int}, 0);
    check("rst_ctrl", ctrl, 32'h0000_A000);
    rst = 1'b0;

    // V1
    access(10'd0, 1'b0, 0, 4'hF, 0);
    access(10'd4, 1'b0, 0, 4'hF, 0);
    check("v1_cnt", m_cnt, 32'd2);

    // strobe without cycle is ignored
    @(negedge clk);
    stb = 1'b1; cyc = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("stb_only_ack", {31'b0, ack}, 0);
    end
    stb = 1'b0;

    // V2
    access(10'd3, 1'b1, 32'hDEAD_BEEF, 4'b0101, 0);
    access(10'd3, 1'b0, 0, 4'hF, 0);
    check("v2_model", m_scr, 32'h00AD_00EF);
    @(negedge clk);
    adr = 10'd3; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("held_ack", {31'b0, ack}, {31'b0, i % 2 == 0});
      check("held_dat", dat_r, (i % 2 == 0) ? 32'h00AD_00EF : 0);
    end
    cyc = 1'b0; stb = 1'b0;
    m_cnt = m_cnt + 2;

    // V3
    access(10'd5, 1'b1, 32'h1234_5678, 4'hF, 0);
    access(10'd4, 1'b1, 32'h1234_5678, 4'hF, 0);
    access(10'd4, 1'b0, 0, 4'hF, 0);

    // V4
    access(10'd2, 1'b1, 32'h4, 4'hF, 0);
    @(negedge clk);
    evt = 8'h04;
    @(posedge clk); #1;
    evt = 8'h00;
    check("v4_int_lag", {31'b0, irq_int}, 0);
    @(posedge clk); #1;
    check("v4_int_set", {31'b0, irq_int}, 1);
    m_src = m_src | 32'h4;
    access(10'd1, 1'b1, 32'h4, 4'hF, 8'h04);
    access(10'd1, 1'b0, 0, 4'hF, 0);
    check("v4_src_kept", m_src & 32'h4, 32'h4);

    // V5
    @(negedge clk);
    force dut.xfer_cnt = 32'hFFFF_FFFF;
    #1 release dut.xfer_cnt;
    m_cnt = 32'hFFFF_FFFF;
    access(10'd4, 1'b0, 0, 4'hF, 0);
    access(10'd4, 1'b0, 0, 4'hF, 0);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] e;
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      access(10'($urandom_range(0, 6)), 1'($urandom),
             $urandom, 4'($urandom), e);
    end

    // V6
    access(10'd2, 1'b1, 32'hFF, 4'hF, 0);
    access(10'd0, 1'b0, 0, 4'hF, 8'hFF);
    check("v6_int_pre", {31'b0, irq_int}, 1);
    @(negedge clk);
    adr = 10'd0; we = 1'b1; dat_w = 32'h1234_5678;
    sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b1;
    #1;
    check("v6_ack", {31'b0, ack}, 0);
    check("v6_err", {31'b0, err}, 0);
    check("v6_dat", dat_r, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("v6_ctrl", ctrl, 32'h0000_A000);
    check("v6_int", {31'b0, irq_int}, 0);
    check("v6_ack2", {31'b0, ack}, 0);
    access(10'd0, 1'b0, 0, 4'hF, 0);
    access(10'd4, 1'b0, 0, 4'hF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
